// File: rtl/pipelined_execute_unit_pkg.sv
// Shared definitions for the pipelined execute unit: operation encodings,
// FSM state type, default widths and a divide-op classifier.
package pipelined_execute_unit_pkg;

  localparam int unsigned REGISTER_WIDTH_DEFAULT = 32;
  localparam int unsigned TAG_WIDTH_DEFAULT      = 5;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } exec_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/pipelined_execute_unit_if.sv
// Operand/result handshake bundle of the execute unit.
//   in_valid/in_ready, op, operand_a, operand_b, tag_in : issue side
//   out_valid/out_ready, result, tag_out               : writeback side
//   busy                                               : divider active
// master = issuing/consuming stage, slave = execute unit.
interface pipelined_execute_unit_if
  import pipelined_execute_unit_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = REGISTER_WIDTH_DEFAULT,
  parameter int unsigned TAG_WIDTH      = TAG_WIDTH_DEFAULT
);
  logic                      in_valid;
  logic                      in_ready;
  alu_op_t                   op;
  logic [REGISTER_WIDTH-1:0] operand_a;
  logic [REGISTER_WIDTH-1:0] operand_b;
  logic [TAG_WIDTH-1:0]      tag_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [REGISTER_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]      tag_out;
  logic                      busy;

  modport master (
    output in_valid, op, operand_a, operand_b, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, busy
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, busy
  );
endinterface

// File: rtl/pipelined_execute_unit_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   start     : load dividend/divisor (ignored bits of a previous run are lost)
//   done      : high during the cycle whose clock edge retires the last bit,
//               so quotient/remainder are final from the following cycle
//   quotient  : dividend / divisor (all ones when divisor is zero)
//   remainder : dividend % divisor (dividend when divisor is zero)
module serial_divider #(
  parameter int unsigned REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [REGISTER_WIDTH-1:0] dividend,
  input  logic [REGISTER_WIDTH-1:0] divisor,
  output logic                      done,
  output logic [REGISTER_WIDTH-1:0] quotient,
  output logic [REGISTER_WIDTH-1:0] remainder
);
  localparam int unsigned CW = $clog2(REGISTER_WIDTH + 1);

  logic [CW-1:0]             count;
  logic [REGISTER_WIDTH-1:0] quo;
  logic [REGISTER_WIDTH-1:0] rem;
  logic [REGISTER_WIDTH-1:0] dvsr;
  logic [REGISTER_WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try a subtract;
  // a set MSB means the subtract underflowed and the old value is restored.
  always_comb begin
    trial = {rem, quo[REGISTER_WIDTH-1]} - {1'b0, dvsr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
    end else if (start) begin
      count <= CW'(REGISTER_WIDTH);
      quo   <= dividend;
      rem   <= '0;
      dvsr  <= divisor;
    end else if (count != '0) begin
      count <= count - CW'(1);
      quo   <= {quo[REGISTER_WIDTH-2:0], ~trial[REGISTER_WIDTH]};
      rem   <= trial[REGISTER_WIDTH] ? {rem[REGISTER_WIDTH-2:0], quo[REGISTER_WIDTH-1]}
                                     : trial[REGISTER_WIDTH-1:0];
    end
  end

  always_comb begin
    done      = (count == CW'(1));
    quotient  = quo;
    remainder = rem;
  end
endmodule

// File: rtl/pipelined_execute_unit.sv
// Registered execute unit: single-cycle ALU/multiply ops (latency 1) and
// multi-cycle RV32M divide/remainder (latency REGISTER_WIDTH+2).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : issue handshake (in_*), result handshake (out_*), busy
// The output register is the only visible state; in_* never reach out_*
// combinationally.
module pipelined_execute_unit
  import pipelined_execute_unit_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = REGISTER_WIDTH_DEFAULT,
  parameter int unsigned TAG_WIDTH      = TAG_WIDTH_DEFAULT,
  parameter int unsigned SHAMT_WIDTH    = $clog2(REGISTER_WIDTH)
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_execute_unit_if.slave bus
);
  localparam int unsigned W = REGISTER_WIDTH;

  exec_state_t          state, state_next;
  logic                 out_free;
  logic                 is_div;
  logic                 div_start, load_single, load_div;
  logic [W-1:0]         alu_result, div_result;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [2*W-1:0]       mul_a, mul_b, product;

  logic                 div_is_rem, a_neg, b_neg, div_by_zero;
  logic [TAG_WIDTH-1:0] div_tag;
  logic                 signed_div;
  logic [W-1:0]         mag_a, mag_b;
  logic                 div_done;
  logic [W-1:0]         div_quo, div_rem;

  always_comb begin
    out_free = !bus.out_valid || bus.out_ready;
    is_div   = is_div_op(bus.op);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid && out_free && is_div) state_next = DIVIDE;
      DIVIDE:  if (div_done) state_next = FINISH;
      FINISH:  if (out_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready = (state == IDLE) && out_free;
    bus.busy     = (state != IDLE);
    div_start    = (state == IDLE) && out_free && bus.in_valid && is_div;
    load_single  = (state == IDLE) && out_free && bus.in_valid && !is_div;
    load_div     = (state == FINISH) && out_free;
  end

  // Single-cycle datapath; one 2W-bit multiplier serves all four multiply
  // flavours by choosing the operand extension per op.
  always_comb begin
    shamt = bus.operand_b[SHAMT_WIDTH-1:0];
    mul_a = (bus.op == OP_MULH || bus.op == OP_MULHSU)
            ? {{W{bus.operand_a[W-1]}}, bus.operand_a} : {{W{1'b0}}, bus.operand_a};
    mul_b = (bus.op == OP_MULH)
            ? {{W{bus.operand_b[W-1]}}, bus.operand_b} : {{W{1'b0}}, bus.operand_b};
    product = mul_a * mul_b;
    case (bus.op)
      OP_ADD:    alu_result = bus.operand_a + bus.operand_b;
      OP_SUB:    alu_result = bus.operand_a - bus.operand_b;
      OP_AND:    alu_result = bus.operand_a & bus.operand_b;
      OP_OR:     alu_result = bus.operand_a | bus.operand_b;
      OP_XOR:    alu_result = bus.operand_a ^ bus.operand_b;
      OP_SLL:    alu_result = bus.operand_a << shamt;
      OP_SRL:    alu_result = bus.operand_a >> shamt;
      OP_SRA:    alu_result = $unsigned($signed(bus.operand_a) >>> shamt);
      OP_SLT:    alu_result = {{(W-1){1'b0}}, $signed(bus.operand_a) < $signed(bus.operand_b)};
      OP_SLTU:   alu_result = {{(W-1){1'b0}}, bus.operand_a < bus.operand_b};
      OP_MUL:    alu_result = product[W-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_result = product[2*W-1:W];
      default:   alu_result = '0;
    endcase
  end

  // Divide prologue: strip signs before the unsigned core, keep the fixups.
  always_comb begin
    signed_div = (bus.op == OP_DIV) || (bus.op == OP_REM);
    mag_a = (signed_div && bus.operand_a[W-1]) ? -bus.operand_a : bus.operand_a;
    mag_b = (signed_div && bus.operand_b[W-1]) ? -bus.operand_b : bus.operand_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_is_rem  <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      div_by_zero <= 1'b0;
      div_tag     <= '0;
    end else if (div_start) begin
      div_is_rem  <= (bus.op == OP_REM) || (bus.op == OP_REMU);
      a_neg       <= signed_div && bus.operand_a[W-1];
      b_neg       <= signed_div && bus.operand_b[W-1];
      div_by_zero <= (bus.operand_b == '0);
      div_tag     <= bus.tag_in;
    end
  end

  serial_divider #(.REGISTER_WIDTH(W)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign correction. The core already yields remainder = |a| for a zero
  // divisor, so re-applying a's sign returns operand_a unchanged; only the
  // quotient needs forcing to all ones. MIN / -1 also falls out naturally:
  // |MIN| = MIN, quotient MIN with no negation, remainder 0.
  always_comb begin
    if (div_is_rem)       div_result = a_neg ? -div_rem : div_rem;
    else if (div_by_zero) div_result = '1;
    else                  div_result = (a_neg ^ b_neg) ? -div_quo : div_quo;
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.tag_out   <= '0;
    end else if (load_single) begin
      bus.out_valid <= 1'b1;
      bus.result    <= alu_result;
      bus.tag_out   <= bus.tag_in;
    end else if (load_div) begin
      bus.out_valid <= 1'b1;
      bus.result    <= div_result;
      bus.tag_out   <= div_tag;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipelined_execute_unit.sv
// Scoreboard bench for pipelined_execute_unit: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_pipelined_execute_unit;
  import pipelined_execute_unit_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int unsigned acc_cyc;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_execute_unit_if #(.REGISTER_WIDTH(W), .TAG_WIDTH(5)) bus ();

  pipelined_execute_unit #(.REGISTER_WIDTH(W), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  bit          chk_lat = 1'b1;
  bit          rand_ready = 1'b0;
  logic        ready_force = 1'b1;
  logic        rnd_ready = 1'b1;

  assign bus.out_ready = rand_ready ? rnd_ready : ready_force;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: RISC-V semantics in plain integer arithmetic.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sbv;
    logic [63:0] p;
    logic [31:0] r;
    sa = a;
    sbv = b;
    r = '0;
    case (alu_op_t'(o))
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_SLL:    r = a << b[4:0];
      OP_SRL:    r = a >> b[4:0];
      OP_SRA:    r = sa >>> b[4:0];
      OP_SLT:    r = (sa < sbv) ? 32'd1 : 32'd0;
      OP_SLTU:   r = (a < b) ? 32'd1 : 32'd0;
      OP_MUL:    r = a * b;
      OP_MULH:   begin p = longint'(sa) * longint'(sbv); r = p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      OP_DIV:    if (b == 0) r = 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                 else r = sa / sbv;
      OP_REM:    if (b == 0) r = a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                 else r = sa % sbv;
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   r = (b == 0) ? a : a % b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic int unsigned lat_of(input logic [4:0] o);
    return (o >= 5'd14 && o <= 5'd17) ? W + 2 : 1;
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bit   got;
    exp_t e;
    got = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = alu_op_t'(o);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.tag_in    = t;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.res = model(o, a, b);
        e.tag = t;
        e.acc_cyc = cyc;
        e.lat = chk_lat ? lat_of(o) : 0;
        sb.push_back(e);
        got = 1'b1;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready never rose, required 1 (op %0d)", o);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every output transfer is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got result 0x%08h tag %0d, required no output", bus.result, bus.tag_out);
        end else begin
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("tag", 32'(bus.tag_out), 32'(e.tag));
          if (e.lat != 0) check("latency", cyc - e.acc_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] o;
    int unsigned r;

    // Reset with a request already pending
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.operand_a = 32'd1;
    bus.operand_b = 32'd2;
    bus.tag_in    = 5'd3;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_result", bus.result, 32'd0);
    check("reset_tag", 32'(bus.tag_out), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(OP_ADD, 32'd1, 32'd2, 5'd3);

    // Back-to-back single-cycle ops
    issue(OP_SUB, 32'd5, 32'd7, 5'd1);
    issue(OP_SRA, 32'h8000_0000, 32'd4, 5'd2);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd3);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd4);
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd7);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    issue(5'd25, 32'd123, 32'd456, 5'd9);

    // Divide: stalled upstream and busy for the whole iteration
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10);
    repeat (W + 1) begin
      @(negedge clk);
      check("div_busy_in_ready", {30'd0, bus.busy, bus.in_ready}, 32'd2);
    end
    @(posedge clk);
    #1;
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
    issue(OP_DIVU, 32'd9, 32'd0, 5'd12);
    issue(OP_REMU, 32'd9, 32'd0, 5'd13);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd16);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd17);
    drain();

    // Backpressure on a single-cycle result
    chk_lat = 1'b0;
    ready_force = 1'b0;
    issue(OP_ADD, 32'd100, 32'd23, 5'd18);
    repeat (5) begin
      @(negedge clk);
      check("hold_add_result", bus.result, 32'd123);
      check("hold_add_tag", 32'(bus.tag_out), 32'd18);
      check("hold_add_in_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd19);
    ready_force = 1'b0;
    for (int n = 0; n < 60 && !bus.out_valid; n++) @(negedge clk);
    check("div_completes", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("hold_div_result", bus.result, 32'd14);
      check("hold_div_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    drain();

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd1000, 32'd3, 5'd20);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (W + 8) @(negedge clk);
    check("no_stale_result", {30'd0, bus.out_valid, bus.busy}, 32'd0);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       o = 5'(18 + $urandom_range(0, 13));
      else if (r < 25) o = 5'(14 + $urandom_range(0, 3));
      else             o = 5'($urandom_range(0, 13));
      issue(o, rnd_val(), rnd_val(), 5'($urandom_range(0, 31)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
